// File: rtl/frame_mem_writer.sv
// Receive-side packet RAM writer: stores frames circularly, commits good frames, rewinds on drop.
// Optional statistics counters are enabled with the FRAME_MEM_STATS_EN macro.
module frame_mem_writer #(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic [2:0]        i_state,
  input  logic [7:0]        i_data,
  input  logic              i_dv,
  input  logic              i_change,
  input  logic              i_error,
  input  logic [ADDR_W-1:0] i_rd_ptr,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [ADDR_W-1:0] o_commit_ptr,
  output logic              o_frame_done,
  output logic [ADDR_W-1:0] o_frame_start,
  output logic [10:0]       o_frame_len,
  output logic              o_drop,
  output logic              o_overflow,
  output logic [15:0]       o_good_cnt,
  output logic [15:0]       o_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    COMMIT = 2'd2,
    DROP   = 2'd3
  } state_t;

  localparam logic [10:0]       MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0]       MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0]       LEN_SAT = 11'h7FF;
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] start_r;
  logic [10:0]       len_r;
  logic              sof_s;
  logic              eof_s;
  logic              store_s;
  logic              full_s;
  logic              drop_s;
  logic              wr_s;
  logic              commit_go_s;

  // Frame-level event decode and next-state selection; drop outranks commit.
  always_comb begin
    sof_s       = i_change && (i_state == 3'd3);
    eof_s       = i_change && (i_state == 3'd0);
    store_s     = (state_r == WRITE) && i_dv && (i_state >= 3'd3);
    full_s      = store_s && ((wr_ptr_r + ONE_A) == i_rd_ptr);
    drop_s      = (state_r == WRITE) &&
                  (i_error || (len_r > MAX_L) || full_s || (eof_s && (len_r < MIN_L)));
    wr_s        = store_s && !drop_s;
    commit_go_s = (state_r == WRITE) && eof_s && !drop_s;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (sof_s) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (drop_s) begin
          state_nxt_s = DROP;
        end else if (commit_go_s) begin
          state_nxt_s = COMMIT;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      COMMIT:  state_nxt_s = IDLE;
      DROP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Write pointer, frame start and running length; a drop rewinds to the frame start.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wr_ptr_r <= '0;
      start_r  <= '0;
      len_r    <= 11'd0;
    end else if ((state_r == IDLE) && sof_s) begin
      start_r <= wr_ptr_r;
      len_r   <= 11'd0;
    end else if (drop_s) begin
      wr_ptr_r <= start_r;
    end else if (wr_s) begin
      wr_ptr_r <= wr_ptr_r + ONE_A;
      if (len_r != LEN_SAT) begin
        len_r <= len_r + 11'd1;
      end
    end
  end

  // Registered RAM write port, commit descriptor, pulses and sticky overflow.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= 8'd0;
      o_commit_ptr  <= '0;
      o_frame_done  <= 1'b0;
      o_frame_start <= '0;
      o_frame_len   <= 11'd0;
      o_drop        <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      o_wr_en      <= wr_s;
      o_wr_addr    <= wr_ptr_r;
      o_wr_data    <= i_data;
      o_frame_done <= commit_go_s;
      o_drop       <= drop_s;
      if (commit_go_s) begin
        o_frame_start <= start_r;
        o_frame_len   <= len_r;
        o_commit_ptr  <= wr_ptr_r;
      end
      if (full_s) begin
        o_overflow <= 1'b1;
      end
    end
  end

`ifdef FRAME_MEM_STATS_EN
  logic [15:0] good_cnt_r;
  logic [15:0] drop_cnt_r;

  // Wrapping frame statistics, counted on the one-cycle COMMIT and DROP states.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      good_cnt_r <= 16'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (state_r == COMMIT) begin
        good_cnt_r <= good_cnt_r + 16'd1;
      end
      if (state_r == DROP) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign o_good_cnt = good_cnt_r;
  assign o_drop_cnt = drop_cnt_r;
`else
  assign o_good_cnt = 16'd0;
  assign o_drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_frame_mem_writer.sv
// Bench for frame_mem_writer: directed vector table, hand sequences and random frames vs a frame-level model.
module tb_frame_mem_writer;

  localparam int AW      = 11;
  localparam int M       = 1 << AW;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;

  logic          iclk = 1'b0;
  logic          irst_n;
  logic [2:0]    i_state;
  logic [7:0]    i_data;
  logic          i_dv;
  logic          i_change;
  logic          i_error;
  logic [AW-1:0] i_rd_ptr;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [7:0]    o_wr_data;
  logic [AW-1:0] o_commit_ptr;
  logic          o_frame_done;
  logic [AW-1:0] o_frame_start;
  logic [10:0]   o_frame_len;
  logic          o_drop;
  logic          o_overflow;
  logic [15:0]   o_good_cnt;
  logic [15:0]   o_drop_cnt;

  always #5 iclk = ~iclk;

  frame_mem_writer #(.ADDR_W(AW), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .iclk(iclk), .irst_n(irst_n), .i_state(i_state), .i_data(i_data), .i_dv(i_dv),
    .i_change(i_change), .i_error(i_error), .i_rd_ptr(i_rd_ptr),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_commit_ptr(o_commit_ptr), .o_frame_done(o_frame_done),
    .o_frame_start(o_frame_start), .o_frame_len(o_frame_len),
    .o_drop(o_drop), .o_overflow(o_overflow),
    .o_good_cnt(o_good_cnt), .o_drop_cnt(o_drop_cnt)
  );

  typedef struct {
    int n; int err_at; int rd; bit err_eof;
    int exp_w; bit exp_done; bit exp_drop; int exp_start; int exp_len; int exp_commit; bit exp_ovf;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] mon_addr[$];
  logic [7:0]    mon_data[$];
  int            mon_done, mon_drop, mon_start, mon_len;
  logic [AW-1:0] exp_addr[$];
  logic [7:0]    exp_data[$];
  int            m_ptr, m_commit, m_good, m_dropc, m_start;
  bit            m_ovf;
  logic [7:0]    fdata[0:1599];
  vec_t          tbl[15];

  // Output monitor, sampling on the falling edge.
  always @(negedge iclk) begin
    if (o_wr_en) begin
      mon_addr.push_back(o_wr_addr);
      mon_data.push_back(o_wr_data);
    end
    if (o_frame_done) begin
      mon_done  = mon_done + 1;
      mon_start = int'(o_frame_start);
      mon_len   = int'(o_frame_len);
    end
    if (o_drop) mon_drop = mon_drop + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_addr.delete(); mon_data.delete(); exp_addr.delete(); exp_data.delete();
    mon_done = 0; mon_drop = 0; mon_start = -1; mon_len = -1;
  endtask

  task automatic idle_inputs();
    i_change = 1'b0; i_state = 3'd0; i_dv = 1'b0; i_error = 1'b0; i_data = 8'd0;
  endtask

  task automatic fill_data();
    for (int i = 0; i < 1600; i++) fdata[i] = 8'($urandom);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_commit = 0; m_good = 0; m_dropc = 0; m_ovf = 1'b0; m_start = 0;
  endtask

  // Frame-level reference: first byte hitting error, oversize or full ring ends the stores.
  task automatic model_frame(input int n, input int err_at, input int rd, input bit err_eof,
                             output bit done, output int wcnt);
    int k;
    bit full;
    k = -1;
    done = 1'b0;
    for (int i = 0; i < n; i++) begin
      full = (((m_ptr + i + 1) % M) == rd);
      if (i == err_at || i > MAX_LEN || full) begin
        k = i;
        if (full) m_ovf = 1'b1;
        break;
      end
    end
    wcnt = (k >= 0) ? k : n;
    for (int j = 0; j < wcnt; j++) begin
      exp_addr.push_back(AW'((m_ptr + j) % M));
      exp_data.push_back(fdata[j]);
    end
    if (k >= 0 || err_eof || n < MIN_LEN || n > MAX_LEN) begin
      m_dropc++;
    end else begin
      done = 1'b1;
      m_good++;
      m_start  = m_ptr;
      m_ptr    = (m_ptr + n) % M;
      m_commit = m_ptr;
    end
  endtask

  task automatic drive_frame(input int n, input int err_at, input bit err_eof, input int idle);
    int st, prev;
    @(negedge iclk);
    i_change = 1'b1; i_state = 3'd3; i_dv = 1'b0; i_error = 1'b0;
    prev = 3;
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      st = (i < 6) ? 3 : (i < 12) ? 4 : (i < 14) ? 5 : (i >= n - 4) ? 7 : 6;
      i_state  = 3'(st);
      i_change = (st != prev);
      i_dv     = 1'b1;
      i_data   = fdata[i];
      i_error  = (i == err_at);
      prev     = st;
    end
    @(negedge iclk);
    i_change = 1'b1; i_state = 3'd0; i_dv = 1'b0; i_error = err_eof; i_data = 8'd0;
    for (int i = 0; i < idle; i++) begin
      @(negedge iclk);
      idle_inputs();
    end
  endtask

  task automatic check_frame(input string name, input int exp_w, input bit exp_done, input bit exp_drop,
                             input int exp_start, input int exp_len, input int exp_commit, input bit exp_ovf);
    int mism, lim;
    int eg, ed;
    @(posedge iclk);
    #1;
    chk({name, " wr_count"}, mon_addr.size(), exp_w);
    mism = 0;
    lim = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
    for (int i = 0; i < lim; i++)
      if (mon_addr[i] != exp_addr[i] || mon_data[i] != exp_data[i]) mism++;
    chk({name, " wr_content_mismatches"}, mism, 0);
    chk({name, " done_pulses"}, mon_done, int'(exp_done));
    chk({name, " drop_pulses"}, mon_drop, int'(exp_drop));
    if (exp_done) begin
      chk({name, " frame_start"}, mon_start, exp_start);
      chk({name, " frame_len"}, mon_len, exp_len);
    end
    chk({name, " commit_ptr"}, int'(o_commit_ptr), exp_commit);
    chk({name, " overflow"}, int'(o_overflow), int'(exp_ovf));
`ifdef FRAME_MEM_STATS_EN
    eg = m_good % 65536; ed = m_dropc % 65536;
`else
    eg = 0; ed = 0;
`endif
    chk({name, " good_cnt"}, int'(o_good_cnt), eg);
    chk({name, " drop_cnt"}, int'(o_drop_cnt), ed);
  endtask

  initial begin
    bit   done;
    int   wcnt, n, err_at, rd;
    bit   err_eof;
    //           n     err  rd    eof   w     dn    dr    start len   commit ovf
    tbl[0]  = '{64,   -1,  0,    1'b0, 64,   1'b1, 1'b0, 0,    64,   64,    1'b0};
    tbl[1]  = '{64,   20,  0,    1'b0, 20,   1'b0, 1'b1, 0,    0,    64,    1'b0};
    tbl[2]  = '{64,   -1,  0,    1'b0, 64,   1'b1, 1'b0, 64,   64,   128,   1'b0};
    tbl[3]  = '{40,   -1,  0,    1'b0, 40,   1'b0, 1'b1, 0,    0,    128,   1'b0};
    tbl[4]  = '{1600, -1,  0,    1'b0, 1523, 1'b0, 1'b1, 0,    0,    128,   1'b0};
    tbl[5]  = '{1000, -1,  0,    1'b0, 1000, 1'b1, 1'b0, 128,  1000, 1128,  1'b0};
    tbl[6]  = '{912,  -1,  0,    1'b0, 912,  1'b1, 1'b0, 1128, 912,  2040,  1'b0};
    tbl[7]  = '{100,  -1,  1000, 1'b0, 100,  1'b1, 1'b0, 2040, 100,  92,    1'b0};
    tbl[8]  = '{64,   -1,  102,  1'b0, 9,    1'b0, 1'b1, 0,    0,    92,    1'b1};
    tbl[9]  = '{64,   -1,  92,   1'b0, 64,   1'b1, 1'b0, 92,   64,   156,   1'b1};
    tbl[10] = '{64,   -1,  156,  1'b1, 64,   1'b0, 1'b1, 0,    0,    156,   1'b1};
    tbl[11] = '{1523, -1,  156,  1'b0, 1523, 1'b0, 1'b1, 0,    0,    156,   1'b1};
    tbl[12] = '{1522, -1,  156,  1'b0, 1522, 1'b1, 1'b0, 156,  1522, 1678,  1'b1};
    tbl[13] = '{63,   -1,  1678, 1'b0, 63,   1'b0, 1'b1, 0,    0,    1678,  1'b1};
    tbl[14] = '{64,   -1,  1678, 1'b0, 64,   1'b1, 1'b0, 1678, 64,   1742,  1'b1};

    irst_n = 1'b0;
    i_rd_ptr = '0;
    idle_inputs();
    clear_mon();
    model_reset();
    repeat (3) @(negedge iclk);
    #1;
    chk("reset wr_en", int'(o_wr_en), 0);
    chk("reset commit_ptr", int'(o_commit_ptr), 0);
    chk("reset frame_done", int'(o_frame_done), 0);
    chk("reset drop", int'(o_drop), 0);
    chk("reset overflow", int'(o_overflow), 0);
    chk("reset good_cnt", int'(o_good_cnt), 0);
    chk("reset drop_cnt", int'(o_drop_cnt), 0);
    @(negedge iclk);
    irst_n = 1'b1;

    // Directed vector table.
    for (int k = 0; k < 15; k++) begin
      fill_data();
      clear_mon();
      i_rd_ptr = AW'(tbl[k].rd);
      model_frame(tbl[k].n, tbl[k].err_at, tbl[k].rd, tbl[k].err_eof, done, wcnt);
      drive_frame(tbl[k].n, tbl[k].err_at, tbl[k].err_eof, 4);
      check_frame($sformatf("vec%0d", k), tbl[k].exp_w, tbl[k].exp_done, tbl[k].exp_drop,
                  tbl[k].exp_start, tbl[k].exp_len, tbl[k].exp_commit, tbl[k].exp_ovf);
    end

    // A DA pulse landing in the COMMIT cycle must be ignored with its whole frame.
    fill_data();
    clear_mon();
    i_rd_ptr = AW'(m_commit);
    model_frame(64, -1, m_commit, 1'b0, done, wcnt);
    drive_frame(64, -1, 1'b0, 0);
    drive_frame(64, -1, 1'b0, 4);
    check_frame("da_in_commit", 64, 1'b1, 1'b0, m_start, 64, m_commit, m_ovf);

    // Reset mid-frame: no drop pulse, next frame starts from address 0.
    fill_data();
    clear_mon();
    @(negedge iclk);
    i_change = 1'b1; i_state = 3'd3;
    for (int i = 0; i < 30; i++) begin
      @(negedge iclk);
      i_change = 1'b0; i_dv = 1'b1; i_data = fdata[i];
    end
    @(negedge iclk);
    irst_n = 1'b0;
    idle_inputs();
    @(negedge iclk);
    #1;
    chk("midreset drop_pulses", mon_drop, 0);
    chk("midreset commit_ptr", int'(o_commit_ptr), 0);
    chk("midreset overflow", int'(o_overflow), 0);
    chk("midreset wr_en", int'(o_wr_en), 0);
    @(negedge iclk);
    irst_n = 1'b1;
    model_reset();
    clear_mon();
    i_rd_ptr = '0;
    model_frame(64, -1, 0, 1'b0, done, wcnt);
    drive_frame(64, -1, 1'b0, 4);
    check_frame("after_reset", 64, 1'b1, 1'b0, 0, 64, 64, 1'b0);

    // Randomized frames against the model.
    for (int r = 0; r < 20; r++) begin
      fill_data();
      clear_mon();
      n       = $urandom_range(20, 1600);
      err_at  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      err_eof = ($urandom_range(0, 7) == 0);
      rd      = ($urandom_range(0, 5) == 0) ? (m_ptr + $urandom_range(2, n)) % M : m_commit;
      i_rd_ptr = AW'(rd);
      model_frame(n, err_at, rd, err_eof, done, wcnt);
      drive_frame(n, err_at, err_eof, 4);
      check_frame($sformatf("rand%0d", r), wcnt, done, !done, m_start, n, m_commit, m_ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_mem_writer.md
FRAME_MEM_WRITER -- requirements
Module: frame_mem_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning packet RAM address width (2^ADDR_W bytes, circular).
REQ-002 SHALL have parameter MIN_LEN, default 64, meaning minimum accepted frame length (DA through FCS, bytes).
REQ-003 SHALL have parameter MAX_LEN, default 1522, meaning maximum accepted frame length (bytes).
REQ-004 SHALL have port iclk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port irst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_state  input  3  receiver state code: 0 no frame, 3 DA, 4 SA, 5 length, 6 data, 7 FCS.
REQ-007 SHALL have port i_data  input  8  receiver byte, aligned with i_dv.
REQ-008 SHALL have port i_dv  input  1  byte valid.
REQ-009 SHALL have port i_change  input  1  one-cycle pulse on a receiver state change.
REQ-010 SHALL have port i_error  input  1  receiver error flag.
REQ-011 SHALL have port i_rd_ptr  input  ADDR_W  reader's free pointer, i.e. the first byte not yet consumed.
REQ-012 SHALL have ports o_wr_en (1), o_wr_addr (ADDR_W) and o_wr_data (8), all outputs, forming the RAM write port.
REQ-013 SHALL have port o_commit_ptr  output  ADDR_W  end of the last committed frame.
REQ-014 SHALL have ports o_frame_done (1), o_frame_start (ADDR_W) and o_frame_len (11), all outputs, forming the commit descriptor.
REQ-015 SHALL have ports o_drop (1) and o_overflow (1), both outputs: drop pulse and sticky overflow flag.
REQ-016 SHALL have ports o_good_cnt (16) and o_drop_cnt (16), both outputs, carrying the statistics counters.

Function
REQ-017 SHALL implement FSM IDLE, WRITE, COMMIT, DROP; COMMIT and DROP each last exactly one cycle, then return to IDLE.
REQ-018 SHALL go IDLE->WRITE on i_change=1 with i_state=3, capturing start=wr_ptr and clearing len.
REQ-019 SHALL in WRITE store a byte when i_dv=1 and i_state is in 3..7: the next cycle o_wr_en=1, o_wr_addr=wr_ptr, o_wr_data=i_data (1-cycle latency).
REQ-020 SHALL advance wr_ptr by 1 mod 2^ADDR_W per stored byte, and increment len saturating at 2047.
REQ-021 SHALL go WRITE->COMMIT on i_change=1 with i_state=0 when no drop condition holds.
REQ-022 SHALL drop the frame on i_error=1 while in WRITE.
REQ-023 SHALL drop the frame on len>MAX_LEN.
REQ-024 SHALL drop the frame on a store attempt when (wr_ptr+1) mod 2^ADDR_W == i_rd_ptr; this also sets o_overflow and suppresses the write.
REQ-025 SHALL drop the frame at end of frame when len<MIN_LEN.
REQ-026 SHALL on any drop go WRITE->DROP.
REQ-027 SHALL in COMMIT pulse o_frame_done=1 for 1 cycle with o_frame_start=start and o_frame_len=len, and set o_commit_ptr=wr_ptr.
REQ-028 SHALL in DROP rewind wr_ptr to start, pulse o_drop=1 for 1 cycle, and leave o_commit_ptr unchanged.
REQ-029 SHALL give drop priority over commit when an error and end-of-frame occur in the same cycle.
REQ-030 SHALL ignore a DA start pulse arriving while in COMMIT or DROP; that frame is not stored.
REQ-031 SHALL keep o_overflow at 1 until reset once set.
REQ-032 SHALL let wr_ptr wrap past 2^ADDR_W-1 to 0 with no effect on len.

Reset
REQ-033 SHALL on irst_n=0 force FSM=IDLE, wr_ptr=start=len=0, o_commit_ptr=0, all pulses 0, o_overflow=0 and both counters 0, asynchronously.
REQ-034 SHALL when reset occurs mid-frame discard the partial frame with no o_drop pulse; the first frame after release begins at address 0.

Configuration
REQ-035 SHALL with FRAME_MEM_STATS_EN defined increment o_good_cnt on each COMMIT and o_drop_cnt on each DROP, both 16-bit and wrapping 0xFFFF->0.
REQ-036 SHALL without FRAME_MEM_STATS_EN keep both counter ports present and constant 0, with no counter logic synthesized.

Verification
REQ-037 SHALL cover: 64-byte good frame from reset, i_rd_ptr=0 -> 64 writes at addr 0..63, o_frame_done with start=0, len=64, o_commit_ptr=64.
REQ-038 SHALL cover: i_error=1 at byte 20 of a frame starting at addr 64 -> o_drop pulse, next frame starts at addr 64, o_commit_ptr stays 64.
REQ-039 SHALL cover: 40-byte frame -> o_drop at end of frame; 1600-byte frame -> o_drop when len reaches 1523.
REQ-040 SHALL cover: ADDR_W=11, wr_ptr=2040, 100-byte frame with i_rd_ptr=1000 -> addresses wrap 2047->0, commit start=2040, o_commit_ptr=92.
REQ-041 SHALL cover: i_rd_ptr=wr_ptr+10 with a 64-byte frame -> 9 bytes written, o_overflow=1 (sticky), o_drop pulse.
REQ-042 SHALL cover: with FRAME_MEM_STATS_EN, 3 good and 2 dropped frames -> o_good_cnt=3, o_drop_cnt=2; without the macro both read 0.
